// File: rtl/uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx : oversampled UART receiver, valid/ready holding register   (rev 1.0)
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_16x,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   shift;
  logic                   rx_s;

  // Chain resets to idle-high so a reset never looks like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= '1;
    else        sync <= {sync[SYNC_STAGES-2:0], rx};
  end

  assign rx_s = sync[SYNC_STAGES-1];
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // A delivery later in this block overrides this consume.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (tick_16x) begin
            if (cnt == HALF_LAST) begin
              if (!rx_s) begin
                state   <= S_DATA;
                cnt     <= '0;
                bit_idx <= '0;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_DATA: begin
          if (tick_16x) begin
            if (cnt == BIT_LAST) begin
              shift <= {rx_s, shift[DATA_BITS-1:1]};
              cnt   <= '0;
              if (bit_idx == IDX_LAST) state   <= S_STOP;
              else                     bit_idx <= bit_idx + BW'(1);
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_STOP: begin
          if (tick_16x) begin
            if (cnt == BIT_LAST) begin
              cnt <= '0;
              if (rx_s) begin
                state <= S_IDLE;
                if (!rx_valid || rx_ready) begin
                  rx_data  <= shift;
                  rx_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end else begin
                frame_err <= 1'b1;
                state     <= S_WAIT_HIGH;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_WAIT_HIGH: begin
          // A held break must not be mistaken for a new start bit.
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
